// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the MAC processing element:
//   - default widths/depth used by mac_pe_param
//   - controller state encoding
//   - small helpers for signed accumulator limits
// ----------------------------------------------------------------------------
package pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int ACC_W_DEF  = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } pe_state_t;

endpackage : pe_pkg

// File: rtl/pe_mac.sv
// ----------------------------------------------------------------------------
// pe_mac
// Purely combinational multiply-accumulate step:
//   acc_out = acc_in + w * a
// The product is formed at full 2*DATA_W signed precision, sign-extended to
// ACC_W and added with one guard bit so overflow can be detected. With
// SAT != 0 the result clamps to the signed ACC_W range, otherwise it wraps.
//
// Ports
//   acc_in  : ACC_W   signed running accumulator
//   w       : DATA_W  signed weight
//   a       : DATA_W  signed activation
//   acc_out : ACC_W   signed updated accumulator
// ----------------------------------------------------------------------------
module pe_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int SAT    = 1
) (
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] a,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W:0]    acc_wide;
    logic signed [ACC_W:0]    prod_wide;
    logic signed [ACC_W:0]    sum;
    logic                     overflow;

    // Operands are widened before the multiply so the full-precision
    // product never depends on context-width rules.
    always_comb begin
        w_ext     = {{DATA_W{w[DATA_W-1]}}, w};
        a_ext     = {{DATA_W{a[DATA_W-1]}}, a};
        product   = w_ext * a_ext;
        acc_wide  = {acc_in[ACC_W-1], acc_in};
        prod_wide = {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
        sum       = acc_wide + prod_wide;
        // The guard bit disagreeing with the ACC_W sign bit means the true
        // result left the representable signed range.
        overflow  = sum[ACC_W] ^ sum[ACC_W-1];
        acc_out   = sum[ACC_W-1:0];
        if ((SAT != 0) && overflow) begin
            acc_out = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule : pe_mac

// File: rtl/mac_pe_param.sv
// ----------------------------------------------------------------------------
// mac_pe_param
// Parameterised MAC processing element. Holds DEPTH signed weights and
// activations and, on request, computes their dot product one entry per
// cycle into a signed ACC_W accumulator (optionally saturating).
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_w, wr_a        : write data_in into weight / activation entry wr_idx
//   wr_idx            : IDX_W write index
//   data_in           : DATA_W write data
//   shift, shift_in   : shift activations down one entry, shift_in enters top
//   start, acc_mode   : launch a dot product; acc_mode=1 keeps the old acc
//   clear             : zero accumulator/result and abort to IDLE
//   busy              : dot product in progress (register files frozen)
//   out_valid         : result available on data_out
//   out_ready         : consumer accepts result
//   data_out          : ACC_W signed result
// ----------------------------------------------------------------------------
module mac_pe_param
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SAT    = 1,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_w,
    input  logic              wr_a,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] data_in,
    input  logic              shift,
    input  logic [DATA_W-1:0] shift_in,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              clear,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  data_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    pe_state_t state;
    pe_state_t next_state;

    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] w_reg [DEPTH];
    logic signed [DATA_W-1:0] a_reg [DEPTH];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  mac_out;
    logic signed [DATA_W-1:0] w_sel;
    logic signed [DATA_W-1:0] a_sel;
    logic                     rf_open;
    logic                     last_mac;

    assign rf_open  = (state != ST_COMP);
    assign last_mac = (state == ST_COMP) && (idx == LAST_IDX);
    assign w_sel    = w_reg[idx];
    assign a_sel    = a_reg[idx];

    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_mac (
        .acc_in  (acc),
        .w       (w_sel),
        .a       (a_sel),
        .acc_out (mac_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // clear is checked last so it overrides start and out_ready.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_COMP;
                end
            end
            ST_COMP: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (clear) begin
            next_state = ST_IDLE;
        end
    end

    // Accumulator, MAC index and result register. acc_mode is only looked at
    // on the launching edge; the accumulator otherwise persists between dot
    // products so results can be chained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            data_out <= '0;
        end else if (clear) begin
            acc      <= '0;
            idx      <= '0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx <= '0;
                        if (!acc_mode) begin
                            acc <= '0;
                        end
                    end
                end
                ST_COMP: begin
                    acc <= mac_out;
                    idx <= idx + IDX_W'(1);
                    if (last_mac) begin
                        data_out <= mac_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Weight file: written only when not computing, and only if no shift is
    // requested on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_reg[i] <= '0;
            end
        end else if (rf_open && !shift && wr_w) begin
            w_reg[wr_idx] <= data_in;
        end
    end

    // Activation file: shift has top priority, then a direct write only if no
    // weight write claims the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_reg[i] <= '0;
            end
        end else if (rf_open) begin
            if (shift) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    a_reg[i] <= a_reg[i+1];
                end
                a_reg[DEPTH-1] <= shift_in;
            end else if (!wr_w && wr_a) begin
                a_reg[wr_idx] <= data_in;
            end
        end
    end

endmodule : mac_pe_param

// File: tb/tb_mac_pe_param.sv
// ----------------------------------------------------------------------------
// tb_mac_pe_param
// Three instances share one stimulus stream: a 20-bit saturating reference
// configuration plus 16-bit saturating and 16-bit wrapping variants. Expected
// results are queued when a dot product is launched; a monitor pops and
// compares on every out_valid/out_ready handshake.
// ----------------------------------------------------------------------------
module tb_mac_pe_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = 20;
    localparam int IDX_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              wr_w;
    logic              wr_a;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] data_in;
    logic              shift;
    logic [DATA_W-1:0] shift_in;
    logic              start;
    logic              acc_mode;
    logic              clear;
    logic              out_ready;

    logic              busy_m, valid_m;
    logic [ACC_W-1:0]  dout_m;
    logic              busy_s, valid_s;
    logic [15:0]       dout_s;
    logic              busy_r, valid_r;
    logic [15:0]       dout_r;

    int checks = 0;
    int errors = 0;
    int cycle_count = 0;
    int start_cycle = 0;
    logic prev_valid = 1'b0;

    longint exp_main[$];
    longint exp_sat[$];
    longint exp_wrap[$];

    mac_pe_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .SAT(1)) u_main (
        .clk(clk), .rst_n(rst_n), .wr_w(wr_w), .wr_a(wr_a), .wr_idx(wr_idx),
        .data_in(data_in), .shift(shift), .shift_in(shift_in), .start(start),
        .acc_mode(acc_mode), .clear(clear), .busy(busy_m), .out_valid(valid_m),
        .out_ready(out_ready), .data_out(dout_m)
    );

    mac_pe_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(16), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .wr_w(wr_w), .wr_a(wr_a), .wr_idx(wr_idx),
        .data_in(data_in), .shift(shift), .shift_in(shift_in), .start(start),
        .acc_mode(acc_mode), .clear(clear), .busy(busy_s), .out_valid(valid_s),
        .out_ready(out_ready), .data_out(dout_s)
    );

    mac_pe_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(16), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .wr_w(wr_w), .wr_a(wr_a), .wr_idx(wr_idx),
        .data_in(data_in), .shift(shift), .shift_in(shift_in), .start(start),
        .acc_mode(acc_mode), .clear(clear), .busy(busy_r), .out_valid(valid_r),
        .out_ready(out_ready), .data_out(dout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: result presented with empty scoreboard (t=%0t)", name, $time);
    endtask

    // Monitor: compares on handshake, and checks launch-to-valid latency.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (valid_m) begin
                if (exp_main.size() == 0) reportUnexpected("main_result");
                else checkOutput("main_data_out", $signed(dout_m), exp_main.pop_front());
            end
            if (valid_s) begin
                if (exp_sat.size() == 0) reportUnexpected("sat_result");
                else checkOutput("sat_data_out", $signed(dout_s), exp_sat.pop_front());
            end
            if (valid_r) begin
                if (exp_wrap.size() == 0) reportUnexpected("wrap_result");
                else checkOutput("wrap_data_out", $signed(dout_r), exp_wrap.pop_front());
            end
        end
        if (valid_m && !prev_valid) begin
            checkOutput("main_latency", cycle_count - start_cycle, DEPTH);
        end
        prev_valid <= valid_m;
    end

    // Drives one edge worth of controls starting at a negedge, then idles them.
    task automatic applyStimulus(input logic do_ww, input logic do_wa, input logic do_shift,
                                 input logic do_start, input logic mode, input logic do_clear,
                                 input int idx, input int data, input int sh_in);
        wr_w     = do_ww;
        wr_a     = do_wa;
        shift    = do_shift;
        start    = do_start;
        acc_mode = mode;
        clear    = do_clear;
        wr_idx   = IDX_W'(idx);
        data_in  = DATA_W'(data);
        shift_in = DATA_W'(sh_in);
        @(negedge clk);
        wr_w  = 1'b0;
        wr_a  = 1'b0;
        shift = 1'b0;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic writeW(input int idx, input int data);
        applyStimulus(1, 0, 0, 0, 0, 0, idx, data, 0);
    endtask

    task automatic writeA(input int idx, input int data);
        applyStimulus(0, 1, 0, 0, 0, 0, idx, data, 0);
    endtask

    task automatic startDot(input logic mode, input longint em, input longint es, input longint ew);
        exp_main.push_back(em);
        exp_sat.push_back(es);
        exp_wrap.push_back(ew);
        applyStimulus(0, 0, 0, 1, mode, 0, 0, 0, 0);
        start_cycle = cycle_count;
    endtask

    task automatic waitResults();
        for (int i = 0; i < 40; i++) begin
            if (exp_main.size() == 0 && exp_sat.size() == 0 && exp_wrap.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("result_timeout", exp_main.size() + exp_sat.size() + exp_wrap.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr_w = 0; wr_a = 0; wr_idx = '0; data_in = '0; shift = 0;
        shift_in = '0; start = 0; acc_mode = 0; clear = 0; out_ready = 1'b1;
        #2;
        checkOutput("reset_busy", busy_m, 0);
        checkOutput("reset_valid", valid_m, 0);
        checkOutput("reset_data_out", dout_m, 0);

        // Start on the very first edge after release; all entries are zero.
        @(negedge clk);
        rst_n = 1'b1;
        startDot(0, 0, 0, 0);
        waitResults();

        for (int i = 0; i < DEPTH; i++) begin
            writeW(i, i + 1);
            writeA(i, i + 5);
        end

        // 70 with consumer stalled; writes during COMP must be ignored.
        out_ready = 1'b0;
        startDot(0, 70, 70, 70);
        checkOutput("busy_in_comp", busy_m, 1);
        writeA(3, 100);
        for (int i = 0; i < 10 && !valid_m; i++) @(negedge clk);
        checkOutput("valid_rise", valid_m, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(k == 1, 0, 0, k == 0, 0, 0, 0, 1, 0);
            checkOutput("hold_valid", valid_m, 1);
            checkOutput("hold_data", $signed(dout_m), 70);
            checkOutput("hold_busy", busy_m, 0);
        end
        out_ready = 1'b1;
        waitResults();
        checkOutput("retain_data", $signed(dout_m), 70);
        checkOutput("after_hs_valid", valid_m, 0);
        repeat (DEPTH + 2) @(negedge clk);
        checkOutput("second_start_ignored", busy_m | valid_m, 0);

        // a = {6,7,8,0}: 6+14+24 = 44, then chained 88.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        startDot(0, 44, 44, 44);
        waitResults();
        startDot(1, 88, 88, 88);
        waitResults();

        // clear beats start; acc is zeroed so a chained start gives 44.
        applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("clear_busy", busy_m, 0);
        checkOutput("clear_data_out", dout_m, 0);
        repeat (2) @(negedge clk);
        checkOutput("clear_stays_idle", busy_m | valid_m, 0);
        startDot(1, 44, 44, 44);
        waitResults();

        // shift beats writes: a = {7,8,0,2}, w unchanged -> 7+16+0+8 = 31.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 9, 2);
        startDot(0, 31, 31, 31);
        waitResults();
        // wr_w beats wr_a: w = {1,5,3,4} -> 7+40+0+8 = 55.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 5, 0);
        startDot(0, 55, 55, 55);
        waitResults();

        // 4*127*127 = 64516: fits in 20 bits, clamps at 16, wraps to -1020.
        for (int i = 0; i < DEPTH; i++) begin
            writeW(i, 127);
            writeA(i, 127);
        end
        startDot(0, 64516, 32767, -1020);
        waitResults();

        // Reset in the middle of COMP drops everything immediately.
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy_m, 0);
        checkOutput("midreset_valid", valid_m, 0);
        checkOutput("midreset_data_out", dout_m, 0);
        checkOutput("midreset_sat_data_out", dout_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        startDot(1, 0, 0, 0);
        waitResults();

        checkOutput("queues_empty", exp_main.size() + exp_sat.size() + exp_wrap.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mac_pe_param
